// File: rtl/uart_rx_fifo_if.sv
// Receiver-to-controller byte buffer signal bundle.
// The slave modport is the FIFO; the master modport is the receiver/controller side.
interface uart_rx_fifo_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
);
  logic [DATA_W-1:0] RX_data;
  logic              RX_status;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              clear_ovf;

  modport master (
    output RX_data, RX_status, rd_en, clear_ovf,
    input  rd_data, empty, full, count, overflow
  );

  modport slave (
    input  RX_data, RX_status, rd_en, clear_ovf,
    output rd_data, empty, full, count, overflow
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Circular first-word-fall-through byte FIFO written on each rising edge of RX_status.
// Dropped bytes (write while full without a pop) set a sticky overflow flag.
module uart_rx_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic           sys_clk,
  input  logic           reset,
  uart_rx_fifo_if.slave  bus
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q,  count_d;
  logic              ovf_q,    ovf_d;
  logic              status_q;

  logic wr_req, wr_acc, rd_acc, drop, is_full, is_empty;

  assign is_full  = (count_q == (ADDR_W+1)'(DEPTH));
  assign is_empty = (count_q == '0);
  assign wr_req   = bus.RX_status & ~status_q;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts a write alongside it.
  assign wr_acc   = wr_req & (~is_full | bus.rd_en);
  assign rd_acc   = bus.rd_en & ~is_empty;
  assign drop     = wr_req & is_full & ~bus.rd_en;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase
    if (drop)               ovf_d = 1'b1;
    else if (bus.clear_ovf) ovf_d = 1'b0;
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      // Held high so a strobe already asserted at reset release is not seen as a new byte.
      status_q <= 1'b1;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      status_q <= bus.RX_status;
      if (wr_acc) mem_q[wr_ptr_q] <= bus.RX_data;
    end
  end

  assign bus.rd_data  = is_empty ? '0 : mem_q[rd_ptr_q];
  assign bus.empty    = is_empty;
  assign bus.full     = is_full;
  assign bus.count    = count_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: one task per scenario with inline checks.
module tb_uart_rx_fifo;

  logic sys_clk = 1'b0;
  logic reset   = 1'b1;
  int   total   = 0;
  int   bad     = 0;

  always #5 sys_clk = ~sys_clk;

  uart_rx_fifo_if #(.DATA_W(8), .ADDR_W(4)) bus ();

  uart_rx_fifo #(.DATA_W(8), .DEPTH(16), .ADDR_W(4)) dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .bus     (bus)
  );

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    bus.RX_data = b; bus.RX_status = 1'b1;
    tick();
    bus.RX_status = 1'b0;
    tick();
  endtask

  task automatic pop();
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
  endtask

  task automatic test_reset();
    bus.RX_data = '0; bus.RX_status = 1'b0; bus.rd_en = 1'b0; bus.clear_ovf = 1'b0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", bus.empty); end
    total++; if (bus.full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", bus.full); end
    total++; if (bus.count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", bus.overflow); end
    total++; if (bus.rd_data !== 8'h00) begin bad++; $display("FAIL reset_rd_data got=%h exp=00", bus.rd_data); end
  endtask

  task automatic test_single();
    bus.RX_data = 8'h41; bus.RX_status = 1'b1;
    tick();
    bus.RX_status = 1'b0;
    total++; if (bus.empty !== 1'b0) begin bad++; $display("FAIL single_empty got=%b exp=0", bus.empty); end
    total++; if (bus.count !== 5'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", bus.count); end
    total++; if (bus.rd_data !== 8'h41) begin bad++; $display("FAIL single_rd_data got=%h exp=41", bus.rd_data); end
    tick();
    pop();
    total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL single_pop_empty got=%b exp=1", bus.empty); end
    total++; if (bus.count !== 5'd0) begin bad++; $display("FAIL single_pop_count got=%0d exp=0", bus.count); end
    total++; if (bus.rd_data !== 8'h00) begin bad++; $display("FAIL single_pop_rd_data got=%h exp=00", bus.rd_data); end
  endtask

  task automatic test_long_strobe();
    bus.RX_data = 8'h55; bus.RX_status = 1'b1;
    repeat (5) tick();
    bus.RX_status = 1'b0;
    tick();
    total++; if (bus.count !== 5'd1) begin bad++; $display("FAIL long_count got=%0d exp=1", bus.count); end
    total++; if (bus.rd_data !== 8'h55) begin bad++; $display("FAIL long_rd_data got=%h exp=55", bus.rd_data); end
    pop();
    total++; if (bus.count !== 5'd0) begin bad++; $display("FAIL long_drain got=%0d exp=0", bus.count); end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < 16; i++) push(8'(i));
    total++; if (bus.full !== 1'b1) begin bad++; $display("FAIL fill_full got=%b exp=1", bus.full); end
    total++; if (bus.count !== 5'd16) begin bad++; $display("FAIL fill_count got=%0d exp=16", bus.count); end
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL fill_ovf_pre got=%b exp=0", bus.overflow); end
    push(8'h10);
    total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL drop_ovf got=%b exp=1", bus.overflow); end
    total++; if (bus.count !== 5'd16) begin bad++; $display("FAIL drop_count got=%0d exp=16", bus.count); end
    for (int i = 0; i < 16; i++) begin
      total++; if (bus.rd_data !== 8'(i)) begin bad++; $display("FAIL drain_%0d got=%h exp=%h", i, bus.rd_data, 8'(i)); end
      pop();
    end
    total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%b exp=1", bus.empty); end
    total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", bus.overflow); end
    bus.clear_ovf = 1'b1; tick(); bus.clear_ovf = 1'b0;
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", bus.overflow); end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
    bus.RX_data = 8'hAA; bus.RX_status = 1'b1; bus.rd_en = 1'b1;
    tick();
    bus.RX_status = 1'b0; bus.rd_en = 1'b0;
    total++; if (bus.count !== 5'd16) begin bad++; $display("FAIL fullrw_count got=%0d exp=16", bus.count); end
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL fullrw_ovf got=%b exp=0", bus.overflow); end
    total++; if (bus.rd_data !== 8'h21) begin bad++; $display("FAIL fullrw_head got=%h exp=21", bus.rd_data); end
    tick();
    // drop and clear in the same cycle: set must win
    bus.RX_data = 8'hBB; bus.RX_status = 1'b1; bus.clear_ovf = 1'b1;
    tick();
    bus.RX_status = 1'b0; bus.clear_ovf = 1'b0;
    total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL setwins_ovf got=%b exp=1", bus.overflow); end
    total++; if (bus.count !== 5'd16) begin bad++; $display("FAIL setwins_count got=%0d exp=16", bus.count); end
    bus.clear_ovf = 1'b1; tick(); bus.clear_ovf = 1'b0;
    for (int i = 1; i < 16; i++) begin
      total++; if (bus.rd_data !== 8'h20 + 8'(i)) begin bad++; $display("FAIL fullrw_drain_%0d got=%h exp=%h", i, bus.rd_data, 8'h20 + 8'(i)); end
      pop();
    end
    total++; if (bus.rd_data !== 8'hAA) begin bad++; $display("FAIL fullrw_last got=%h exp=aa", bus.rd_data); end
    pop();
    total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL fullrw_empty got=%b exp=1", bus.empty); end
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL fullrw_ovf_clr got=%b exp=0", bus.overflow); end
  endtask

  task automatic test_empty_push_pop();
    bus.RX_data = 8'h33; bus.RX_status = 1'b1; bus.rd_en = 1'b1;
    tick();
    bus.RX_status = 1'b0; bus.rd_en = 1'b0;
    total++; if (bus.count !== 5'd1) begin bad++; $display("FAIL emptyrw_count got=%0d exp=1", bus.count); end
    total++; if (bus.rd_data !== 8'h33) begin bad++; $display("FAIL emptyrw_rd_data got=%h exp=33", bus.rd_data); end
    tick();
    pop();
    pop();
    total++; if (bus.count !== 5'd0) begin bad++; $display("FAIL underflow_count got=%0d exp=0", bus.count); end
    total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL underflow_empty got=%b exp=1", bus.empty); end
    total++; if (bus.rd_data !== 8'h00) begin bad++; $display("FAIL underflow_rd_data got=%h exp=00", bus.rd_data); end
    push(8'h44);
    total++; if (bus.count !== 5'd1) begin bad++; $display("FAIL after_underflow_count got=%0d exp=1", bus.count); end
    total++; if (bus.rd_data !== 8'h44) begin bad++; $display("FAIL after_underflow_data got=%h exp=44", bus.rd_data); end
    pop();
  endtask

  task automatic test_reset_mid();
    push(8'h01); push(8'h02); push(8'h03);
    total++; if (bus.count !== 5'd3) begin bad++; $display("FAIL mid_pre_count got=%0d exp=3", bus.count); end
    bus.RX_data = 8'h77; bus.RX_status = 1'b1;
    #1 reset = 1'b1;
    #1;
    total++; if (bus.count !== 5'd0) begin bad++; $display("FAIL mid_count got=%0d exp=0", bus.count); end
    total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL mid_empty got=%b exp=1", bus.empty); end
    total++; if (bus.rd_data !== 8'h00) begin bad++; $display("FAIL mid_rd_data got=%h exp=00", bus.rd_data); end
    tick();
    reset = 1'b0;
    repeat (3) tick();
    total++; if (bus.count !== 5'd0) begin bad++; $display("FAIL held_strobe_count got=%0d exp=0", bus.count); end
    bus.RX_status = 1'b0;
    tick();
    push(8'h99);
    total++; if (bus.count !== 5'd1) begin bad++; $display("FAIL post_reset_count got=%0d exp=1", bus.count); end
    total++; if (bus.rd_data !== 8'h99) begin bad++; $display("FAIL post_reset_data got=%h exp=99", bus.rd_data); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_long_strobe();
    test_fill_overflow();
    test_full_push_pop();
    test_empty_push_pop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Byte buffer between the UART receiver and the command controller. It captures one byte on each rising edge of the receiver's RX_status strobe and stores it in a DEPTH-entry circular FIFO. The head byte is presented first-word-fall-through, so the controller can consume bursts at its own pace without losing characters. A sticky flag reports any bytes dropped while the FIFO was full.

Parameters:
DATA_W, 8, byte width; matches RX_data.
DEPTH, 16, number of entries; must be a power of 2 and at least 2.
ADDR_W, 4, log2(DEPTH); pointer width.

Ports:
sys_clk  input  1  system clock; all logic on the rising edge.
reset  input  1  asynchronous, active-high reset.
RX_data  input  DATA_W  received byte from the receiver; valid in the cycle RX_status rises.
RX_status  input  1  receiver done strobe; high for 1 or more cycles per byte.
rd_en  input  1  controller pops the head byte this cycle.
rd_data  output  DATA_W  head byte; 0 when empty.
empty  output  1  FIFO holds 0 bytes.
full  output  1  FIFO holds DEPTH bytes.
count  output  ADDR_W+1  number of stored bytes, 0..DEPTH.
overflow  output  1  sticky; set when a byte was dropped.
clear_ovf  input  1  synchronous clear of overflow.

Behaviour:
- Reset (async assert, sync release):
  - wr_ptr = rd_ptr = 0, count = 0.
  - empty = 1, full = 0, overflow = 0, rd_data = 0.
  - Storage array cleared to 0.
  - Registered copy status_q is reset to 1, so a RX_status held high across reset release does not produce a write.
- Write detect:
  - wr_req = RX_status & ~status_q; status_q <= RX_status every cycle.
  - RX_data is sampled in the wr_req cycle.
  - A multi-cycle-high RX_status yields exactly one write.
- Write accept = wr_req & (~full | rd_en).
  - On accept: mem[wr_ptr] <= RX_data, wr_ptr <= wr_ptr+1 (mod DEPTH).
- Read accept = rd_en & ~empty.
  - On accept: rd_ptr <= rd_ptr+1 (mod DEPTH).
  - rd_en while empty is ignored; no state change.
- count update per cycle: +1 on write only, -1 on read only, unchanged on both or neither.
  - empty = (count==0); full = (count==DEPTH). Both are registered or derived from registered count; no combinational path from inputs.
- Latency:
  - Byte written at edge N is visible on rd_data with empty=0 after edge N.
  - No write-to-read bypass: when empty, a simultaneous wr_req and rd_en writes the byte and ignores the read.
- rd_data = mem[rd_ptr] when ~empty, else 0. This is a combinational read of registered storage, so it changes right after the pop edge.
- Full with wr_req:
  - With rd_en: pop and push in the same cycle; count stays DEPTH; no overflow.
  - Without rd_en: byte dropped, overflow <= 1, pointers and count unchanged.
- overflow is cleared by clear_ovf. If a drop and clear_ovf occur in the same cycle, set wins (overflow = 1).
- Pointer wrap is modulo DEPTH. full and empty are distinguished by count, never by pointer compare alone.
- Reset mid-operation discards all stored bytes immediately.

Test Plan:
1. Reset, then pulse RX_status 1 cycle with RX_data=8'h41 -> next cycle empty=0, count=1, rd_data=8'h41. Then rd_en 1 cycle -> empty=1, count=0, rd_data=0.
2. Hold RX_status high 5 cycles with RX_data=8'h55 -> exactly one write; count=1.
3. Write 16 bytes 8'h00..8'h0F -> full=1, count=16. 17th write 8'h10 without rd_en -> dropped, overflow=1, count=16. Drain all 16 -> order 00..0F, empty=1. clear_ovf -> overflow=0.
4. Full, then wr_req(8'hAA) with rd_en in the same cycle -> count stays 16, overflow=0. After draining, the last byte read is 8'hAA.
5. Empty, then wr_req(8'h33) with rd_en in the same cycle -> count=1, rd_data=8'h33. rd_en while empty -> no change, no underflow.
6. Write 3 bytes, assert reset mid-stream -> count=0, empty=1, rd_data=0 immediately. RX_status held high through reset release -> no write; the next genuine rising edge writes normally.
